// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: phase encoding, 640x480@60 defaults, totals.
package vga_pkg;

  // Phase of a line (or of a frame, counted in lines)
  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int vga_h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vga_v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-clock divider: one-cycle tick every CLK_DIV system clocks.
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running count; tick is registered so it is 0 out of reset even for CLK_DIV=1
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters + phase FSMs (stage 0),
// registered syncs/enable/colours one pixel behind (stage 1).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 1,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oPixelTick,
  output logic [XW-1:0]      oX,
  output logic [YW-1:0]      oY,
  output logic               oLineStart,
  output logic               oFrameStart,
  output logic               oActive,
  output logic               oHsync,
  output logic               oVsync,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB
);

  localparam int H_TOTAL = vga_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [XW-1:0] H_ACT_N   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] H_FP_END  = XW'(H_ACTIVE + H_FP - 1);
  localparam logic [XW-1:0] H_SYN_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_N   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] V_FP_END  = YW'(V_ACTIVE + V_FP - 1);
  localparam logic [YW-1:0] V_SYN_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);

  // Counter widths must hold the last position of a line / frame
  if (H_TOTAL > 2**XW) begin : g_bad_xw
    $error("H_TOTAL does not fit in XW");
  end
  if (V_TOTAL > 2**YW) begin : g_bad_yw
    $error("V_TOTAL does not fit in YW");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end

  logic               tick;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  phase_e             h_ph, v_ph, h_nxt, v_nxt;
  logic               parked;
  logic               line_q, frame_q;
  logic               h_wrap, v_wrap, act_now;
  logic               act_q, hs_q, vs_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick)
  );

  assign h_wrap  = (x_q == H_LAST);
  assign v_wrap  = (y_q == V_LAST);
  assign act_now = (x_q < H_ACT_N) && (y_q < V_ACT_N);

  // Next phase of both FSMs from the counter boundary reached this pixel
  always_comb begin
    h_nxt = h_ph;
    v_nxt = v_ph;
    case (h_ph)
      PH_ACT: if (x_q == H_ACT_END) h_nxt = PH_FP;
      PH_FP:  if (x_q == H_FP_END)  h_nxt = PH_SYN;
      PH_SYN: if (x_q == H_SYN_END) h_nxt = PH_BP;
      PH_BP:  if (h_wrap)           h_nxt = PH_ACT;
    endcase
    case (v_ph)
      PH_ACT: if (y_q == V_ACT_END) v_nxt = PH_FP;
      PH_FP:  if (y_q == V_FP_END)  v_nxt = PH_SYN;
      PH_SYN: if (y_q == V_SYN_END) v_nxt = PH_BP;
      PH_BP:  if (v_wrap)           v_nxt = PH_ACT;
    endcase
  end

  // Stage 0: counters, phase FSMs and start strobes. After reset or a disable
  // the counters sit parked at (0,0); the first enabled tick only re-announces
  // (0,0) as a new frame without advancing.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x_q     <= '0;
      y_q     <= '0;
      h_ph    <= PH_ACT;
      v_ph    <= PH_ACT;
      parked  <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (tick) begin
        if (!iEnable) begin
          x_q    <= '0;
          y_q    <= '0;
          h_ph   <= PH_ACT;
          v_ph   <= PH_ACT;
          parked <= 1'b1;
        end else if (parked) begin
          parked  <= 1'b0;
          line_q  <= 1'b1;
          frame_q <= 1'b1;
        end else begin
          h_ph <= h_nxt;
          if (h_wrap) begin
            x_q    <= '0;
            line_q <= 1'b1;
            v_ph   <= v_nxt;
            if (v_wrap) begin
              y_q     <= '0;
              frame_q <= 1'b1;
            end else begin
              y_q <= y_q + 1'b1;
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
    end
  end

  // Stage 1: enable, syncs and colours for the pixel stage 0 held this period
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      act_q <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else if (tick) begin
      if (!iEnable || parked) begin
        act_q <= 1'b0;
        hs_q  <= ~H_POL;
        vs_q  <= ~V_POL;
        r_q   <= '0;
        g_q   <= '0;
        b_q   <= '0;
      end else begin
        act_q <= act_now;
        hs_q  <= (h_ph == PH_SYN) ? H_POL : ~H_POL;
        vs_q  <= (v_ph == PH_SYN) ? V_POL : ~V_POL;
        r_q   <= act_now ? iRed   : '0;
        g_q   <= act_now ? iGreen : '0;
        b_q   <= act_now ? iBlue  : '0;
      end
    end
  end

  assign oPixelTick  = tick;
  assign oX          = x_q;
  assign oY          = y_q;
  assign oLineStart  = line_q & iEnable;
  assign oFrameStart = frame_q & iEnable;
  assign oActive     = act_q;
  assign oHsync      = hs_q;
  assign oVsync      = vs_q;
  assign oR          = r_q;
  assign oG          = g_q;
  assign oB          = b_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. Generalises the fixed 640x480 sync generator with:
- configurable porch, sync and active lengths, and sync polarity
- an internal pixel-clock divider
- multi-bit colour channels
- pixel coordinate outputs and frame/line strobes

It sits between the system clock domain and the VGA connector pins, and feeds coordinates to the pixel source (framebuffer or pattern logic).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, asserted level of oHsync (0 = active-low)
V_POL, 0, asserted level of oVsync
CLK_DIV, 2, Clock cycles per pixel (>=1)
COLOR_W, 1, bits per colour channel
XW, 11, width of oX
YW, 10, width of oY

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
iEnable  in  1  run timing; low = blank and park at (0,0)
iRed  in  COLOR_W  red for pixel (oX,oY)
iGreen  in  COLOR_W  green for pixel (oX,oY)
iBlue  in  COLOR_W  blue for pixel (oX,oY)
oPixelTick  out  1  one-Clock strobe, once per pixel period
oX  out  XW  horizontal counter, 0..H_TOTAL-1
oY  out  YW  vertical counter, 0..V_TOTAL-1
oLineStart  out  1  one-Clock strobe when oX becomes 0
oFrameStart  out  1  one-Clock strobe when (oX,oY) becomes (0,0)
oActive  out  1  registered display enable, aligned with oR/oG/oB
oHsync  out  1  horizontal sync
oVsync  out  1  vertical sync
oR  out  COLOR_W  red to DAC/pins
oG  out  COLOR_W  green to DAC/pins
oB  out  COLOR_W  blue to DAC/pins

Behaviour:
- Clocking: one clock, Clock. Reset is asynchronous and active-low (Reset = 0 resets).
- Reset values:
  - divider, oX, oY = 0
  - oPixelTick, oLineStart, oFrameStart, oActive, colours = 0
  - oHsync = ~H_POL, oVsync = ~V_POL (deasserted)
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Divider:
  - counts 0..CLK_DIV-1; tick when count = CLK_DIV-1
  - oPixelTick is high for that one Clock cycle
  - CLK_DIV = 1 gives a tick every cycle
- Stage 0 (counters), advancing only on tick:
  - oX wraps at H_TOTAL-1 to 0
  - on each horizontal wrap, oY increments
  - oY wraps at V_TOTAL-1 to 0
  - line order is ACTIVE, FP, SYNC, BP; frame order is the same for lines
- Horizontal FSM (H_ACT, H_FP, H_SYN, H_BP), transitions on counter boundaries:
  - H_ACT leaves at oX = H_ACTIVE-1
  - H_FP leaves at oX = H_ACTIVE+H_FP-1
  - H_SYN leaves at oX = H_ACTIVE+H_FP+H_SYNC-1
  - H_BP leaves at oX = H_TOTAL-1
- Vertical FSM: same four states, stepped only on horizontal wrap.
- Stage 1 (output register), updated on tick:
  - oActive <= (oX < H_ACTIVE) && (oY < V_ACTIVE)
  - oHsync <= H_POL when in H_SYN, else ~H_POL; oVsync likewise with V_POL
  - colours <= iRGB when active, else 0
  - Result: oActive, syncs and colours lag oX/oY by exactly one pixel period.
  - The pixel source has one pixel period to present the colour for (oX,oY).
- Strobes:
  - oLineStart and oFrameStart are registered and high for the single Clock cycle following the tick that loads oX = 0 (resp. oX = 0, oY = 0).
  - They are never asserted while iEnable = 0.
- iEnable low:
  - on next tick, counters load (0,0) and hold
  - FSMs go to ACT, syncs deasserted, colours 0, oActive 0
  - divider keeps running
- iEnable rising: timing resumes from (0,0). The first tick with counters at (0,0) after resuming raises oFrameStart.
- Reset mid-frame: all state returns to reset values immediately; the first frame after release starts at (0,0).
- Arithmetic:
  - counters are unsigned; comparisons use widths XW/YW
  - H_TOTAL must fit in XW and V_TOTAL in YW, checked at elaboration

Decomposition:
- Shared package vga_pkg holds:
  - the 2-bit phase encoding (ACT=0, FP=1, SYN=2, BP=3)
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL helper functions
- One natural sub-module: pixel_tick_div, parametrised by CLK_DIV. Output is the tick strobe; resets to 0.

Test Plan:
1. Defaults, Reset low 5 cycles then high, iEnable=1 -> first oFrameStart within 2 ticks; oHsync low for exactly 96 ticks (192 Clocks) per line; line period 1600 Clocks.
2. Defaults, run 2 frames -> frame period exactly 840000 Clocks; oVsync low for exactly 2 lines (3200 Clocks); oActive high 640x480 = 307200 ticks per frame.
3. iRed=iGreen=iBlue=1 constant -> colours 0 whenever oActive=0; colours 1 exactly one tick after oX/oY enter the active region.
4. H_POL=1, V_POL=1, CLK_DIV=1 -> syncs idle low and pulse high; oPixelTick constantly high; line period 800 Clocks.
5. Deassert iEnable at oX=300, oY=100 for 50 Clocks, then reassert -> counters at (0,0), colours 0, syncs deasserted; next oFrameStart at the first tick after reassertion.
6. Assert Reset low at oX=700, oY=490 (inside vsync) -> oVsync returns to 1 immediately, without waiting for a clock edge; all outputs at reset values.
